// File: rtl/mips_cpu_bus_ctrl.sv
// mips_cpu_bus_ctrl: fixed-priority Avalon-MM master shared by the MIPS fetch and data channels.
// Defining BUS_TIMEOUT_EN adds a waitrequest watchdog that aborts into a sticky ERR state.
module mips_cpu_bus_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic              dm_signed,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_ack,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              busy,
    output logic              bus_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DATA, S_ACK, S_ERR} state_t;

    state_t            state_q, state_d;
    logic              is_data_q, we_q, sgn_q, err_q, to_err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q, rdata_q;

    logic              accept, misalign, timeout, on_bus;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata, lane, rd_ext;

    assign on_bus = (state_q == S_FETCH) || (state_q == S_DATA);

    // Data channel has priority; a fetch always behaves as an aligned word access.
    always_comb begin
        accept    = dm_req | if_req;
        req_addr  = dm_req ? dm_addr : if_addr;
        req_size  = dm_req ? dm_size : 2'b10;
        misalign  = 1'b0;
        req_be    = 4'b1111;
        req_wdata = dm_wdata;
        case (req_size)
            2'b00: begin
                req_be    = 4'b0001 << req_addr[1:0];
                req_wdata = {4{dm_wdata[7:0]}};
            end
            2'b01: begin
                misalign  = req_addr[0];
                req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{dm_wdata[15:0]}};
            end
            default: misalign = |req_addr[1:0];
        endcase
    end

    always_comb begin
        lane = readdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   rd_ext = {{24{sgn_q & lane[7]}}, lane[7:0]};
            2'b01:   rd_ext = {{16{sgn_q & lane[15]}}, lane[15:0]};
            default: rd_ext = readdata;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             bus_err_q;

    assign timeout = on_bus && waitrequest && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err = bus_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            if (on_bus && waitrequest && !timeout)
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            else
                wait_cnt_q <= '0;
            if (timeout)
                bus_err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misalign)    state_d = S_ACK;
                    else if (dm_req) state_d = S_DATA;
                    else             state_d = S_FETCH;
                end
            end
            S_FETCH, S_DATA: begin
                if (timeout || !waitrequest) state_d = S_ACK;
            end
            S_ACK:   state_d = to_err_q ? S_ERR : S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        read   = 1'b0;
        write  = 1'b0;
        if_ack = 1'b0;
        dm_ack = 1'b0;
        busy   = (state_q != S_IDLE);
        case (state_q)
            S_FETCH: read = 1'b1;
            S_DATA: begin
                read  = !we_q;
                write = we_q;
            end
            S_ACK: begin
                if_ack = !is_data_q;
                dm_ack = is_data_q;
            end
            default: ;
        endcase
        if_rdata   = if_ack ? rdata_q : 32'h0;
        if_err     = if_ack & err_q;
        dm_rdata   = dm_ack ? rdata_q : 32'h0;
        dm_err     = dm_ack & err_q;
        address    = {addr_q[ADDR_W-1:2], 2'b00};
        byteenable = be_q;
        writedata  = wdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_data_q <= 1'b0;
            we_q      <= 1'b0;
            sgn_q     <= 1'b0;
            err_q     <= 1'b0;
            to_err_q  <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
        end else if (state_q == S_IDLE && accept) begin
            is_data_q <= dm_req;
            we_q      <= dm_req & dm_we;
            sgn_q     <= dm_req & dm_signed;
            size_q    <= req_size;
            addr_q    <= req_addr;
            be_q      <= req_be;
            wdata_q   <= (dm_req && dm_we) ? req_wdata : 32'h0;
            err_q     <= misalign;
            to_err_q  <= 1'b0;
            rdata_q   <= 32'h0;
        end else if (on_bus) begin
            if (timeout) begin
                err_q    <= 1'b1;
                to_err_q <= 1'b1;
                rdata_q  <= 32'h0;
            end else if (!waitrequest) begin
                rdata_q <= we_q ? 32'h0 : rd_ext;
            end
        end
    end
endmodule

// File: tb/tb_mips_cpu_bus_ctrl.sv
// Bench for mips_cpu_bus_ctrl: directed cases plus random transactions against a transaction-level model.
// The watchdog section runs only when BUS_TIMEOUT_EN is defined.
module tb_mips_cpu_bus_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, dm_signed, waitrequest;
    logic [31:0] if_addr, dm_addr, dm_wdata, readdata;
    logic [1:0]  dm_size;
    logic        if_ack, if_err, dm_ack, dm_err, busy, bus_err, read, write;
    logic [31:0] if_rdata, dm_rdata, address, writedata;
    logic [3:0]  byteenable;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_cpu_bus_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_signed(dm_signed),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .busy(busy), .bus_err(bus_err), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: access width in bytes, natural alignment, little-endian lanes.
    function automatic int nbytes(input bit data, input logic [1:0] size);
        if (!data) return 4;
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] a, input int n);
        logic [3:0] be = 4'b0000;
        int off = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [31:0] wd, input int n);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a, input int n, input bit sgn);
        longint v = 0;
        int off = int'(a % 4);
        for (int j = 0; j < n; j++) v = v + (longint'(rd[8*(off+j) +: 8]) << (8*j));
        if (sgn && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic txn(input bit data, input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                       input int waits, input bit hold_if);
        int          n   = nbytes(data, size);
        bit          mis = (addr % n) != 0;
        logic [31:0] exp_rd;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        if (data) begin
            dm_req = 1'b1; dm_we = we; dm_size = size; dm_signed = sgn;
            dm_addr = addr; dm_wdata = wdata;
            if (hold_if) if_req = 1'b1;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        waitrequest = (waits > 0);
        readdata    = $urandom;
        @(posedge clk);
        if (!mis) begin
            for (int k = 0; k <= waits; k++) begin
                @(negedge clk);
                chk("cmd_read", read, data ? !we : 1'b1);
                chk("cmd_write", write, data & we);
                chk("cmd_addr", address, addr & 32'hFFFF_FFFC);
                chk("cmd_be", byteenable, exp_be(addr, n));
                if (data && we) chk("cmd_wdata", writedata, exp_wd(wdata, n));
                chk("early_ack", {30'h0, if_ack, dm_ack}, 32'h0);
                waitrequest = (k < waits);
                readdata    = (k == waits) ? rd : $urandom;
            end
        end
        @(negedge clk);
        exp_rd = (mis || (data && we)) ? 32'h0 : exp_load(rd, addr, n, sgn);
        chk("ack_cmd_off", {30'h0, read, write}, 32'h0);
        chk("ack_dm", dm_ack, data);
        chk("ack_if", if_ack, !data);
        if (data) begin
            chk("dm_rdata", dm_rdata, exp_rd);
            chk("dm_err", dm_err, mis);
            dm_req = 1'b0;
        end else begin
            chk("if_rdata", if_rdata, exp_rd);
            chk("if_err", if_err, mis);
            if_req = 1'b0;
        end
        chk("bus_err_clear", bus_err, 1'b0);
        waitrequest = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bit          d, w;
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_signed = 1'b0;
        dm_size = 2'b00; if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        waitrequest = 1'b0; readdata = 32'h0;
        #23;
        chk("rst_cmd", {30'h0, read, write}, 32'h0);
        chk("rst_flags", {28'h0, busy, bus_err, if_ack, dm_ack}, 32'h0);
        chk("rst_addr", address, 32'h0);
        chk("rst_be", byteenable, 4'h0);
        reset = 1'b1;

        txn(0, 0, 2'b10, 0, 32'hBFC0_0000, 32'h0, 32'h2402_0005, 0, 0);
        txn(1, 1, 2'b00, 0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 3, 0);
        txn(1, 0, 2'b01, 1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
        txn(1, 0, 2'b01, 0, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 0);
        txn(1, 0, 2'b00, 1, 32'h0000_2001, 32'h0, 32'h8001_1234, 0, 0);
        txn(1, 0, 2'b00, 1, 32'h0000_2003, 32'h0, 32'h8001_1234, 2, 0);
        txn(1, 1, 2'b10, 0, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0, 1, 1);
        txn(0, 0, 2'b10, 0, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 0);
        txn(1, 0, 2'b10, 0, 32'h0000_3002, 32'h0, 32'h5555_AAAA, 0, 0);
        txn(1, 0, 2'b11, 1, 32'h0000_4000, 32'h0, 32'h8765_4321, 0, 0);

        // Reset in the middle of a waited fetch.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0100; waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_read", read, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_read_drop", read, 1'b0);
        chk("rst_busy", busy, 1'b0);
        if_req = 1'b0; waitrequest = 1'b0;
        @(negedge clk);
        chk("rst_no_ack", {30'h0, if_ack, dm_ack}, 32'h0);
        reset = 1'b1;
        txn(0, 0, 2'b10, 0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 1, 0);

        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            d = ($urandom_range(0, 2) != 0);
            w = $urandom_range(0, 1) == 1;
            txn(d, w, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, a, $urandom, $urandom,
                $urandom_range(0, 3), 0);
        end

`ifdef BUS_TIMEOUT_EN
        begin
            int cyc = 0;
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h0000_0040; waitrequest = 1'b1;
            @(posedge clk);
            @(negedge clk);
            while (read && cyc < 100) begin
                cyc++;
                @(negedge clk);
            end
            chk("to_cycles", cyc, 16);
            chk("to_if_ack", if_ack, 1'b1);
            chk("to_if_err", if_err, 1'b1);
            chk("to_if_rdata", if_rdata, 32'h0);
            if_req = 1'b0;
            @(negedge clk);
            chk("to_bus_err", bus_err, 1'b1);
            chk("to_busy", busy, 1'b1);
            dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("err_ignores", {28'h0, read, write, if_ack, dm_ack}, 32'h0);
            end
            dm_req = 1'b0; waitrequest = 1'b0;
            reset = 1'b0;
            #1;
            reset = 1'b1;
            @(negedge clk);
            chk("to_rst_bus_err", bus_err, 1'b0);
            chk("to_rst_busy", busy, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
